imem_fetch_ctrl: RTL

//   Sequencer and arbiter for a single-port, nibble-wide instruction memory.

---
 rtl/imem_fetch_ctrl_if.sv | 41 ++++
 rtl/imem_fetch_ctrl.sv | 87 ++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle between the fetch controller, the IF stage, the loader
// and the nibble-wide instruction memory.
interface imem_fetch_ctrl_if #(
    parameter int WORD_LEN       = 16,
    parameter int MEM_CELL_SIZE  = 4,
    parameter int INSTR_MEM_SIZE = 64
);
    localparam int AW = $clog2(INSTR_MEM_SIZE);

    logic                     fetch_req;
    logic [WORD_LEN-1:0]      fetch_addr;
    logic                     fetch_ack;
    logic                     fetch_valid;
    logic [WORD_LEN-1:0]      fetch_instr;
    logic                     load_req;
    logic [AW-1:0]            load_addr;
    logic [MEM_CELL_SIZE-1:0] load_data;
    logic                     load_ack;
    logic [AW-1:0]            mem_addr;
    logic                     mem_we;
    logic [MEM_CELL_SIZE-1:0] mem_wdata;
    logic [MEM_CELL_SIZE-1:0] mem_rdata;

    modport master (
        input  fetch_req, fetch_addr,
        input  load_req, load_addr, load_data,
        input  mem_rdata,
        output fetch_ack, fetch_valid, fetch_instr,
        output load_ack,
        output mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output fetch_req, fetch_addr,
        output load_req, load_addr, load_data,
        output mem_rdata,
        input  fetch_ack, fetch_valid, fetch_instr,
        input  load_ack,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Round-robin sequencer sharing one nibble memory port between
// instruction fetch (four beats per word) and single-cell loads.
module imem_fetch_ctrl #(
    parameter int WORD_LEN       = 16,
    parameter int MEM_CELL_SIZE  = 4,
    parameter int INSTR_MEM_SIZE = 64
) (
    input  logic               clk,
    input  logic               rst,
    imem_fetch_ctrl_if.master  bus
);
    localparam int AW = $clog2(INSTR_MEM_SIZE);
    localparam int SW = WORD_LEN - MEM_CELL_SIZE;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]    state;
    logic [1:0]    beat;
    logic          rr_ptr;
    logic [AW-1:0] base;
    logic [SW-1:0] sr;
    logic          idle;
    logic          grant_fetch;
    logic          grant_load;

    wire unused_addr = ^bus.fetch_addr[WORD_LEN-1:AW];

    // Acks are gated by rst so nothing is granted while held in reset.
    assign idle        = rst && (state == IDLE);
    assign grant_fetch = idle && bus.fetch_req
                         && (!bus.load_req || !rr_ptr);
    assign grant_load  = idle && bus.load_req
                         && (!bus.fetch_req || rr_ptr);

    assign bus.fetch_ack = grant_fetch;
    assign bus.load_ack  = grant_load;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        unique case (1'b1)
            rst && (state == FETCH): begin
                bus.mem_addr = base + AW'(beat);
            end
            grant_load: begin
                bus.mem_addr  = bus.load_addr;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = bus.load_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            beat            <= 2'd0;
            rr_ptr          <= 1'b0;
            base            <= '0;
            sr              <= '0;
            bus.fetch_instr <= '0;
            bus.fetch_valid <= 1'b0;
        end else begin
            bus.fetch_valid <= 1'b0;
            if (grant_fetch) begin
                base   <= bus.fetch_addr[AW-1:0];
                beat   <= 2'd0;
                state  <= FETCH;
                rr_ptr <= 1'b1;
            end
            if (grant_load) begin
                rr_ptr <= 1'b0;
            end
            if (state == FETCH) begin
                sr   <= {sr[SW-MEM_CELL_SIZE-1:0], bus.mem_rdata};
                beat <= beat + 2'd1;
                if (beat == 2'd3) begin
                    state           <= IDLE;
                    bus.fetch_instr <= {sr, bus.mem_rdata};
                    bus.fetch_valid <= 1'b1;
                end
            end
        end
    end
endmodule
